// File: rtl/rom_loader.sv
// 16x8 program RAM filled by a valid/ready byte loader; CPU reads mem[SW] combinationally.
// One write per accepted byte (wr_ready registered from state only); wr_valid low simply stalls.
module rom_loader #(
    parameter bit CLR_ON_START = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic [3:0] SW,
    output logic [7:0] LEDR,
    output logic       busy,
    output logic       done,
    output logic [4:0] wptr,
    output logic [7:0] csum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_mem [16];
    logic [4:0]  r_wptr;
    logic [7:0]  r_csum;
    logic        r_wr_ready;
    logic        r_busy;
    logic        r_done;
    logic        w_xfer;

    // r_wr_ready is only ever high in LOAD, so it doubles as the state qualifier.
    assign w_xfer = wr_valid & r_wr_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_wptr     <= 5'd0;
            r_csum     <= 8'h00;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_wptr     <= 5'd0;
                        r_csum     <= 8'h00;
                        if (CLR_ON_START) begin
                            for (int i = 0; i < 16; i++) begin
                                r_mem[i] <= 8'h00;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    // start is deliberately ignored here so an in-flight image is never disturbed.
                    if (w_xfer) begin
                        r_mem[r_wptr[3:0]] <= wr_data;
                        r_wptr             <= r_wptr + 5'd1;
                        r_csum             <= r_csum + wr_data;
                        if (r_wptr == 5'd15) begin
                            r_state    <= S_DONE;
                            r_wr_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wr_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready = r_wr_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wptr     = r_wptr;
    assign csum     = r_csum;
    assign LEDR     = r_mem[SW];

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboarded bench for rom_loader: a byte-level reference model predicts every cycle's outputs.
module tb_rom_loader;

    logic       CLK;
    logic       RST;
    logic       start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] SW;
    logic [7:0] LEDR;
    logic       busy;
    logic       done;
    logic [4:0] wptr;
    logic [7:0] csum;

    rom_loader #(.CLR_ON_START(1'b1)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .SW       (SW),
        .LEDR     (LEDR),
        .busy     (busy),
        .done     (done),
        .wptr     (wptr),
        .csum     (csum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr_ready;
        logic       busy;
        logic       done;
        logic [4:0] wptr;
        logic [7:0] csum;
        logic [7:0] ledr;
        logic [3:0] sw;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the image as an array, plus "loading" and "complete" flags.
    logic [7:0] m_mem [16];
    bit         m_loading;
    bit         m_done;
    int         m_count;
    int         m_sum;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 0;
        m_done    = 0;
        m_count   = 0;
        m_sum     = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    // Apply one cycle of inputs, advance the model over the edge, push the expectation.
    task automatic step(input bit s, input bit v, input logic [7:0] d, input logic [3:0] sw);
        exp_t e;
        start    = s;
        wr_valid = v;
        wr_data  = d;
        SW       = sw;
        @(posedge CLK);
        if (m_loading) begin
            if (v) begin
                m_mem[m_count] = d;
                m_count++;
                m_sum = (m_sum + d) % 256;
                if (m_count == 16) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end else if (s) begin
            m_loading = 1;
            m_done    = 0;
            m_count   = 0;
            m_sum     = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end
        e.wr_ready = m_loading;
        e.busy     = m_loading;
        e.done     = m_done;
        e.wptr     = 5'(m_count);
        e.csum     = 8'(m_sum);
        e.ledr     = m_mem[sw];
        e.sw       = sw;
        exp_q.push_back(e);
        #2;
    endtask

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("wr_ready", 32'(wr_ready), 32'(e_mon.wr_ready));
            chk("busy",     32'(busy),     32'(e_mon.busy));
            chk("done",     32'(done),     32'(e_mon.done));
            chk("wptr",     32'(wptr),     32'(e_mon.wptr));
            chk("csum",     32'(csum),     32'(e_mon.csum));
            chk($sformatf("LEDR[%0h]", e_mon.sw), 32'(LEDR), 32'(e_mon.ledr));
        end
    end

    task automatic dump(input bit v);
        for (int i = 0; i < 16; i++) step(1'b0, v, 8'($urandom_range(255)), 4'(i));
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic async_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        model_reset();
        chk("rst done",     32'(done),     32'd0);
        chk("rst wr_ready", 32'(wr_ready), 32'd0);
        chk("rst busy",     32'(busy),     32'd0);
        chk("rst wptr",     32'(wptr),     32'd0);
        chk("rst csum",     32'(csum),     32'd0);
        for (int i = 0; i < 3; i++) begin
            SW = 4'($urandom_range(15));
            #1;
            chk("rst LEDR", 32'(LEDR), 32'd0);
        end
        @(posedge CLK);
        #3;
        RST = 1'b1;
    endtask

    initial begin
        RST      = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        SW       = 4'h7;
        model_reset();
        #1;
        chk("init LEDR",     32'(LEDR),     32'd0);
        chk("init done",     32'(done),     32'd0);
        chk("init wr_ready", 32'(wr_ready), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST = 1'b1;

        // Idle: wr_valid alone does nothing.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55, 4'(i));

        // Full back-to-back load of 00..0F.
        step(1'b1, 1'b0, 8'h00, 4'hA);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 4'hA);
        dump(1'b1);

        // Every-other-cycle stall with FF bytes: 31 load cycles.
        step(1'b1, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 31; i++) step(1'b0, (i % 2) == 0, 8'hFF, 4'($urandom_range(15)));
        dump(1'b0);

        // Starts during LOAD are ignored, including one coincident with a transfer.
        step(1'b1, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom_range(255)), 4'(i));
        step(1'b1, 1'b0, 8'h00, 4'h2);
        step(1'b1, 1'b1, 8'h3C, 4'h5);
        for (int i = 6; i < 16; i++) step(1'b0, 1'b1, 8'($urandom_range(255)), 4'(i));
        dump(1'b0);

        // Reload from DONE clears the image.
        step(1'b1, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'hAA, 4'(i));
        step(1'b1, 1'b0, 8'h00, 4'h3);
        dump(1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom_range(255)), 4'($urandom_range(15)));

        // Mid-load reset after 8 transfers; wr_valid held high afterwards writes nothing.
        step(1'b1, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom_range(1, 255)), 4'(i));
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h77, 4'(i));
        dump(1'b1);

        // Randomized loads with random valid, random start pulses and random read addresses.
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 1'($urandom_range(1)), 8'($urandom_range(255)), 4'($urandom_range(15)));
            for (int i = 0; i < 40; i++)
                step(($urandom_range(9) == 0), ($urandom_range(3) != 0),
                     8'($urandom_range(255)), 4'($urandom_range(15)));
            dump(1'($urandom_range(1)));
        end

        @(posedge CLK);
        #4;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
